ex_muldiv: RTL and testbench
============================

// Module: ex_muldiv
// PURPOSE
//  Iterative multiply/divide unit with HI/LO registers for the EX stage of the pipelined CPU.
//  Executes MULT/MULTU/DIV/DIVU over many cycles and owns HI/LO (mfhi/mflo/mthi/mtlo).
//  Holds the pipeline through stall when a later instruction needs HI/LO or the unit.
//  Width is parametrised, generalising the fixed 32-bit datapath.
// PARAMETERS
//  XLEN  32  operand/HI/LO width; XLEN >= 4
// PORTS
//  clk        in   1     clock, rising edge
//  reset      in   1     asynchronous, active-low
//  start      in   1     issue the op in EX this cycle
//  op         in   2     00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//  a          in   XLEN  rs operand (forwarded); dividend / multiplicand
//  b          in   XLEN  rt operand (forwarded); divisor / multiplier
//  kill       in   1     flush (branch/IRQ); aborts the op in flight
//  rd_hilo    in   1     instruction in EX reads HI or LO
//  hilo_wr    in   2     [1] mthi, [0] mtlo; data taken from hilo_wdata
//  hilo_wdata in   XLEN  write data for mthi/mtlo
//  hi         out  XLEN  HI register
//  lo         out  XLEN  LO register
//  busy       out  1     op in flight
//  done       out  1     one-cycle pulse: HI/LO hold the new result
//  stall      out  1     combinational: busy & (start | rd_hilo | |hilo_wr)
// BEHAVIOUR
//  Reset (async, reset=0): state IDLE, count 0, hi=lo=0, busy=0, done=0, so stall=0.
//  FSM states: IDLE -> RUN -> FIX -> IDLE.
//   IDLE: start=1 & kill=0 at edge E0 -> RUN. Capture |a|, |b| for signed ops and the sign flags; count=0; busy=1.
//   RUN: one bit per edge. MUL: shift-add into a 2*XLEN accumulator. DIV: restoring subtract-shift.
//        After XLEN edges (E1..E_XLEN) -> FIX.
//   FIX: at edge E_XLEN+1 apply the sign fix and write HI/LO, then busy=0; done=1 for exactly the next cycle.
//  Latency: start edge to HI/LO update is XLEN+1 edges for every op.
//  Result encoding:
//   MUL: {hi,lo} = 2*XLEN-bit product.
//   DIV: lo = quotient truncated toward zero; hi = remainder with the dividend's sign.
//  Divide by zero: same latency; hi=a, lo={XLEN{1'b1}}; signed and unsigned alike.
//  Signed overflow: MIN / -1 gives lo=MIN, hi=0.
//  start while busy: not accepted; stall=1 until busy falls; the pipeline re-presents start.
//  rd_hilo while busy: stall=1. In the done cycle busy=0, so mfhi/mflo read the new value.
//  hilo_wr:
//   When busy=0, the selected half is written at the next edge.
//   hilo_wr=11 writes both halves.
//   hilo_wr with start in the same idle cycle: the write is applied and the op starts.
//   When busy=1, hilo_wr is ignored and stall=1.
//  kill:
//   When busy, kill goes to IDLE at the next edge; HI/LO keep their prior values and no done pulse is produced.
//   kill with start in IDLE: start is ignored.
//   kill in the FIX cycle: the write is suppressed.
//  done never coincides with busy.
//  Asserting reset mid-op clears everything immediately, including HI/LO.
// CONFIGURATION
//  MULDIV_FAST_MUL_EN defined:
//   MULT/MULTU use a single-cycle combinational multiplier: start edge E0 -> RUN skipped -> FIX writes at E1.
//   done is the cycle after E1; busy is high for one cycle.
//   Divide is unchanged.
//  Not defined: all ops are iterative, as above.
// TESTING  (XLEN=32)
//  MULT a=FFFFFFFD, b=00000007 -> after 33 edges hi=FFFFFFFF, lo=FFFFFFEB; done exactly one cycle; busy 33 cycles.
//  DIVU a=100, b=7 -> lo=0000000E, hi=00000002. DIV a=-7, b=2 -> lo=FFFFFFFD, hi=FFFFFFFF.
//  DIV a=5, b=0 -> hi=00000005, lo=FFFFFFFF. DIV a=80000000, b=FFFFFFFF -> lo=80000000, hi=0.
//  rd_hilo=1 throughout a DIVU -> stall=1 for all 33 busy cycles, 0 in the done cycle.
//   mthi during busy is ignored; mtlo 1234 when idle -> lo=1234.
//  hi/lo=AAAA/5555, start DIV, kill at cycle 10 -> busy=0 next edge, hi/lo stay AAAA/5555, no done.
//   Reset pulsed mid-MULT -> hi=lo=0 at once.
//  MULDIV_FAST_MUL_EN: MULTU FFFFFFFF*FFFFFFFF -> hi=FFFFFFFE, lo=00000001 at E1; done in the following cycle.

Source files
------------

// File: rtl/ex_muldiv_if.sv
// Pipeline-side bundle for the EX-stage multiply/divide unit.
// master: the pipeline (issues ops, reads HI/LO and status).
// slave:  the ex_muldiv unit.
interface ex_muldiv_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [1:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            kill;
  logic            rd_hilo;
  logic [1:0]      hilo_wr;
  logic [XLEN-1:0] hilo_wdata;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;
  logic            busy;
  logic            done;
  logic            stall;

  modport master (
    output start, op, a, b, kill, rd_hilo, hilo_wr, hilo_wdata,
    input  hi, lo, busy, done, stall
  );

  modport slave (
    input  start, op, a, b, kill, rd_hilo, hilo_wr, hilo_wdata,
    output hi, lo, busy, done, stall
  );
endinterface

// File: rtl/ex_muldiv.sv
// Iterative multiply/divide unit owning the HI/LO registers.
// op: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU. Every op takes XLEN+1 edges from
// the start edge to the HI/LO write; the pipeline is held through stall.
// Optional feature macro: MULDIV_FAST_MUL_EN -- multiplies use a single-cycle
// combinational multiplier (start edge -> FIX, HI/LO written one edge later).
module ex_muldiv #(
  parameter int XLEN = 32
) (
  input  logic       clk,
  input  logic       reset,
  ex_muldiv_if.slave bus
);

  localparam int CNT_W = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t              state;
  logic [CNT_W-1:0]    count;
  logic                is_div;
  logic                sign_a;     // dividend/multiplicand was negative (signed ops)
  logic                sign_b;
  logic                div0;       // divide by zero: result preloaded, steps skipped
  logic [XLEN-1:0]     opnd;       // |multiplicand| or |divisor|
  logic [2*XLEN-1:0]   acc;        // MUL: {partial, multiplier}; DIV: {remainder, quotient}
  logic [XLEN-1:0]     hi_q;
  logic [XLEN-1:0]     lo_q;
  logic                busy_q;
  logic                done_q;

  // Operand magnitudes for the signed ops.
  logic            signed_op;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  assign signed_op = ~bus.op[0];
  assign a_mag     = (signed_op && bus.a[XLEN-1]) ? -bus.a : bus.a;
  assign b_mag     = (signed_op && bus.b[XLEN-1]) ? -bus.b : bus.b;

`ifdef MULDIV_FAST_MUL_EN
  localparam bit FAST_MUL = 1'b1;
  logic [2*XLEN-1:0] fast_prod;
  assign fast_prod = {{XLEN{1'b0}}, a_mag} * {{XLEN{1'b0}}, b_mag};
`else
  localparam bit FAST_MUL = 1'b0;
  logic [2*XLEN-1:0] fast_prod;
  assign fast_prod = '0;
`endif

  // One iteration step for each algorithm, plus the final sign fix.
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN:0]     div_shift;
  logic [XLEN:0]     div_diff;
  logic              div_ge;
  logic [2*XLEN-1:0] div_next;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   res_hi;
  logic [XLEN-1:0]   res_lo;

  // Shift-add multiply, restoring divide and the sign-corrected result.
  always_comb begin
    // NOTE: every signal assigned here gets a value on every path first, so no latch is inferred.
    mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
    mul_next  = {mul_sum, acc[XLEN-1:1]};
    div_shift = acc[2*XLEN-1:XLEN-1];
    div_diff  = div_shift - {1'b0, opnd};
    div_ge    = (div_shift >= {1'b0, opnd});
    div_next  = {(div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0]), acc[XLEN-2:0], div_ge};
    prod_fix  = (sign_a ^ sign_b) ? -acc : acc;
    res_hi    = prod_fix[2*XLEN-1:XLEN];
    res_lo    = prod_fix[XLEN-1:0];
    if (is_div) begin
      if (div0) begin
        res_hi = acc[2*XLEN-1:XLEN];
        res_lo = acc[XLEN-1:0];
      end else begin
        res_hi = sign_a            ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        res_lo = (sign_a ^ sign_b) ? -acc[XLEN-1:0]      : acc[XLEN-1:0];
      end
    end
  end

  // Control FSM, datapath registers and HI/LO ownership.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (!reset) begin
      state  <= IDLE;
      count  <= '0;
      is_div <= 1'b0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      div0   <= 1'b0;
      opnd   <= '0;
      acc    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.hilo_wr[1]) hi_q <= bus.hilo_wdata;
          if (bus.hilo_wr[0]) lo_q <= bus.hilo_wdata;
          if (bus.start && !bus.kill) begin
            is_div <= bus.op[1];
            sign_a <= signed_op & bus.a[XLEN-1];
            sign_b <= signed_op & bus.b[XLEN-1];
            div0   <= bus.op[1] && (bus.b == '0);
            count  <= '0;
            busy_q <= 1'b1;
            state  <= RUN;
            if (bus.op[1]) begin
              opnd <= b_mag;
              acc  <= (bus.b == '0) ? {bus.a, {XLEN{1'b1}}} : {{XLEN{1'b0}}, a_mag};
            end else if (FAST_MUL) begin
              opnd  <= a_mag;
              acc   <= fast_prod;
              state <= FIX;
            end else begin
              opnd <= a_mag;
              acc  <= {{XLEN{1'b0}}, b_mag};
            end
          end
        end
        RUN: begin
          if (bus.kill) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else begin
            if (!div0) acc <= is_div ? div_next : mul_next;
            count <= count + 1'b1;
            if (count == CNT_W'(XLEN - 1)) state <= FIX;
          end
        end
        FIX: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          if (!bus.kill) begin
            hi_q   <= res_hi;
            lo_q   <= res_lo;
            done_q <= 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.stall = busy_q & (bus.start | bus.rd_hilo | (|bus.hilo_wr));

endmodule

// File: tb/tb_ex_muldiv.sv
// Scoreboard bench for ex_muldiv (XLEN=32): the stimulus thread pushes the
// expected HI/LO of each completing op; a monitor pops and compares on done.
module tb_ex_muldiv;

  localparam int XLEN = 32;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  localparam logic [1:0] MULT  = 2'b00;
  localparam logic [1:0] MULTU = 2'b01;
  localparam logic [1:0] DIV   = 2'b10;
  localparam logic [1:0] DIVU  = 2'b11;

  typedef struct {
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
    string           name;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];

  ex_muldiv_if #(.XLEN(XLEN)) bus ();
  ex_muldiv #(.XLEN(XLEN)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        if (sb_q.size() == 0) begin
          check("unexpected_done", 64'(bus.done), 64'(0));
        end else begin
          e = sb_q.pop_front();
          check({e.name, "_hi"}, 64'(bus.hi), 64'(e.hi));
          check({e.name, "_lo"}, 64'(bus.lo), 64'(e.lo));
          check({e.name, "_busy_in_done"}, 64'(bus.busy), 64'(0));
        end
      end
    end
  end

  // Called at posedge+1; leaves at posedge+1 just after the start edge.
  task automatic issue(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv,
                       input logic [31:0] eh, input logic [31:0] el, input string name,
                       input bit push);
    if (push) sb_q.push_back('{hi: eh, lo: el, name: name});
    bus.op    = o;
    bus.a     = av;
    bus.b     = bv;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Counts busy cycles (sampled at negedge); returns at the first idle negedge.
  task automatic wait_idle(output int nb);
    nb = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.busy !== 1'b1) break;
      nb++;
    end
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] eh, input logic [31:0] el, input string name,
                        input int lat);
    int nb;
    issue(o, av, bv, eh, el, name, 1'b1);
    wait_idle(nb);
    check({name, "_busy_cycles"}, 64'(nb), 64'(lat));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb;
    int ns;
    int nd;
    bus.start      = 1'b0;
    bus.op         = 2'b00;
    bus.a          = '0;
    bus.b          = '0;
    bus.kill       = 1'b0;
    bus.rd_hilo    = 1'b0;
    bus.hilo_wr    = 2'b00;
    bus.hilo_wdata = '0;
    reset          = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_hi",    64'(bus.hi),    64'(0));
    check("reset_lo",    64'(bus.lo),    64'(0));
    check("reset_busy",  64'(bus.busy),  64'(0));
    check("reset_done",  64'(bus.done),  64'(0));
    check("reset_stall", 64'(bus.stall), 64'(0));
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Directed arithmetic vectors.
    run_op(MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, "mult_m3x7",   MUL_LAT);
    run_op(MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, "mult_minxmin", MUL_LAT);
    run_op(MULTU, 32'h80000000, 32'h00000002, 32'h00000001, 32'h00000000, "multu_carry", MUL_LAT);
    run_op(DIVU,  32'd100,      32'd7,        32'h00000002, 32'h0000000E, "divu_100_7",  DIV_LAT);
    run_op(DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, "div_m7_2",    DIV_LAT);
    run_op(DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, "div_7_m2",    DIV_LAT);
    run_op(DIV,   32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003, "div_m7_m2",   DIV_LAT);
    run_op(DIV,   32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF, "div_by0",     DIV_LAT);
    run_op(DIV,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, "div_neg_by0", DIV_LAT);
    run_op(DIVU,  32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFF, "divu_by0",    DIV_LAT);
    run_op(DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, "div_ovf",     DIV_LAT);

    // rd_hilo held through a DIVU, with an mthi attempted mid-op.
    bus.rd_hilo = 1'b1;
    issue(DIVU, 32'd100, 32'd7, 32'h00000002, 32'h0000000E, "divu_stall", 1'b1);
    nb = 0;
    ns = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.busy !== 1'b1) break;
      nb++;
      if (bus.stall === 1'b1) ns++;
      if (i == 5) begin
        bus.hilo_wr    = 2'b10;
        bus.hilo_wdata = 32'hDEADBEEF;
      end
      if (i == 6) bus.hilo_wr = 2'b00;
    end
    check("stall_busy_cycles",  64'(nb), 64'(33));
    check("stall_cycles",       64'(ns), 64'(33));
    check("stall_in_done",      64'(bus.stall), 64'(0));
    bus.rd_hilo = 1'b0;
    @(posedge clk);
    #1;

    // mtlo while idle.
    bus.hilo_wr    = 2'b01;
    bus.hilo_wdata = 32'h00001234;
    @(posedge clk);
    #1;
    bus.hilo_wr = 2'b00;
    check("mtlo_lo", 64'(bus.lo), 64'(32'h00001234));
    check("mtlo_hi", 64'(bus.hi), 64'(32'h00000002));

    // hi/lo = AAAA/5555, then kill a DIV at busy cycle 10.
    bus.hilo_wr    = 2'b10;
    bus.hilo_wdata = 32'h0000AAAA;
    @(posedge clk);
    #1;
    bus.hilo_wr    = 2'b01;
    bus.hilo_wdata = 32'h00005555;
    @(posedge clk);
    #1;
    bus.hilo_wr = 2'b00;
    issue(DIV, 32'd100, 32'd7, '0, '0, "div_kill", 1'b0);
    repeat (10) @(negedge clk);
    check("kill_busy_before", 64'(bus.busy), 64'(1));
    bus.kill = 1'b1;
    @(posedge clk);
    #1;
    bus.kill = 1'b0;
    check("kill_busy_after", 64'(bus.busy), 64'(0));
    check("kill_hi", 64'(bus.hi), 64'(32'h0000AAAA));
    check("kill_lo", 64'(bus.lo), 64'(32'h00005555));
    nd = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done === 1'b1) nd++;
    end
    check("kill_no_done", 64'(nd), 64'(0));
    @(posedge clk);
    #1;

    // Kill in the FIX cycle suppresses the write.
    issue(DIV, 32'd100, 32'd7, '0, '0, "div_kill_fix", 1'b0);
    repeat (33) @(negedge clk);
    bus.kill = 1'b1;
    @(posedge clk);
    #1;
    bus.kill = 1'b0;
    check("killfix_busy", 64'(bus.busy), 64'(0));
    check("killfix_hi",   64'(bus.hi),   64'(32'h0000AAAA));
    check("killfix_lo",   64'(bus.lo),   64'(32'h00005555));
    nd = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.done === 1'b1) nd++;
    end
    check("killfix_no_done", 64'(nd), 64'(0));
    @(posedge clk);
    #1;

    // kill with start while idle: start ignored.
    bus.kill = 1'b1;
    issue(DIVU, 32'd9, 32'd4, '0, '0, "start_kill", 1'b0);
    bus.kill = 1'b0;
    check("startkill_busy", 64'(bus.busy), 64'(0));

    // Idle write and start in the same cycle: both take effect.
    bus.hilo_wr    = 2'b11;
    bus.hilo_wdata = 32'h00000077;
    issue(DIVU, 32'd9, 32'd4, 32'h00000001, 32'h00000002, "divu_wr_start", 1'b1);
    bus.hilo_wr = 2'b00;
    check("wrstart_hi",   64'(bus.hi),   64'(32'h00000077));
    check("wrstart_lo",   64'(bus.lo),   64'(32'h00000077));
    check("wrstart_busy", 64'(bus.busy), 64'(1));
    @(negedge clk);
    bus.start = 1'b1;
    #1;
    check("start_while_busy_stall", 64'(bus.stall), 64'(1));
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_idle(nb);
    check("wrstart_busy_cycles", 64'(nb), 64'(DIV_LAT - 1));
    @(posedge clk);
    #1;

    // Reset pulsed mid-MULT clears everything at once.
    issue(MULT, 32'h00001234, 32'h00005678, '0, '0, "mult_reset", 1'b0);
    @(negedge clk);
    repeat ((MUL_LAT > 1) ? 9 : 0) @(negedge clk);
    reset = 1'b0;
    #1;
    check("midreset_hi",   64'(bus.hi),   64'(0));
    check("midreset_lo",   64'(bus.lo),   64'(0));
    check("midreset_busy", 64'(bus.busy), 64'(0));
    check("midreset_done", 64'(bus.done), 64'(0));
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    run_op(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, "multu_max", MUL_LAT);

    repeat (3) @(negedge clk);
    if (sb_q.size() != 0) check("scoreboard_empty", 64'(sb_q.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
